// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: scheduler state encoding, default layer
// geometry and the output-map dimension helper.
package lenet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_t;

  localparam int unsigned C1_IMG_W = 28;
  localparam int unsigned C1_IMG_H = 28;
  localparam int unsigned C1_KSIZE = 5;
  localparam int unsigned C3_IMG_W = 14;
  localparam int unsigned C3_IMG_H = 14;
  localparam int unsigned C3_KSIZE = 5;

  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/DffPosRst.sv
// Rising-edge register with asynchronous active-high clear.
module DffPosRst #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/conv_window_cnt.sv
// Nested kx/ky/col/row window counters with incremental read-address and
// output-window-index generation (adds of 1 or IMG_W only).
module conv_window_cnt
  import lenet_pkg::*;
#(
  parameter int unsigned IMG_W      = C1_IMG_W,
  parameter int unsigned IMG_H      = C1_IMG_H,
  parameter int unsigned KSIZE      = C1_KSIZE,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  output logic                  tap0,
  output logic                  last_tap,
  output logic                  last_window,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] win_idx
);

  localparam int unsigned OW = out_dim(IMG_W, KSIZE);
  localparam int unsigned OH = out_dim(IMG_H, KSIZE);
  localparam int unsigned KW = $clog2(KSIZE + 1);
  localparam int unsigned CW = $clog2(OW + 1);
  localparam int unsigned RW = $clog2(OH + 1);

  localparam logic [KW-1:0]         K_LAST   = KW'(KSIZE - 1);
  localparam logic [CW-1:0]         C_LAST   = CW'(OW - 1);
  localparam logic [RW-1:0]         R_LAST   = RW'(OH - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  logic [KW-1:0]         kx, ky;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ADDR_WIDTH-1:0] line_base, win_base, row_base;
  logic                  kx_last, ky_last, col_last, row_last;

  assign kx_last     = (kx == K_LAST);
  assign ky_last     = (ky == K_LAST);
  assign col_last    = (col == C_LAST);
  assign row_last    = (row == R_LAST);
  assign tap0        = (kx == '0) && (ky == '0);
  assign last_tap    = kx_last && ky_last;
  assign last_window = col_last && row_last;

  // line_base = row*IMG_W, win_base = line_base+col, row_base = win_base+ky*IMG_W;
  // addr tracks row_base+kx so every step is a single small add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx        <= '0;
      ky        <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      win_base  <= '0;
      row_base  <= '0;
      addr      <= '0;
      win_idx   <= '0;
    end else if (adv) begin
      if (!kx_last) begin
        kx   <= kx + 1'b1;
        addr <= addr + ONE;
      end else begin
        kx <= '0;
        if (!ky_last) begin
          ky       <= ky + 1'b1;
          row_base <= row_base + ROW_STEP;
          addr     <= row_base + ROW_STEP;
        end else begin
          ky      <= '0;
          win_idx <= last_window ? '0 : win_idx + ONE;
          if (!col_last) begin
            col      <= col + 1'b1;
            win_base <= win_base + ONE;
            row_base <= win_base + ONE;
            addr     <= win_base + ONE;
          end else begin
            col <= '0;
            if (!row_last) begin
              row       <= row + 1'b1;
              line_base <= line_base + ROW_STEP;
              win_base  <= line_base + ROW_STEP;
              row_base  <= line_base + ROW_STEP;
              addr      <= line_base + ROW_STEP;
            end else begin
              row       <= '0;
              line_base <= '0;
              win_base  <= '0;
              row_base  <= '0;
              addr      <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Convolution-layer window scheduler: walks the KSIZE x KSIZE window over the
// input map, issues SRAM reads and drives MAC clear/enable and window tags.
module conv_window_sched
  import lenet_pkg::*;
#(
  parameter int unsigned IMG_W      = C1_IMG_W,
  parameter int unsigned IMG_H      = C1_IMG_H,
  parameter int unsigned KSIZE      = C1_KSIZE,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  sched_state_t          state;
  logic                  drain_cnt;
  logic                  adv;
  logic                  tap0, last_tap, last_window;
  logic [ADDR_WIDTH-1:0] win_idx;
  logic                  v1, d1;
  logic [ADDR_WIDTH-1:0] a1;

  // A bubble only stalls the first tap, so a window is never split mid-MAC.
  assign adv   = (state == RUN) && !(tap0 && !out_ready);
  assign rd_en = adv;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (adv && last_tap && last_window) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= IDLE;
          else           drain_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_window_cnt #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .KSIZE     (KSIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .adv        (adv),
    .tap0       (tap0),
    .last_tap   (last_tap),
    .last_window(last_window),
    .addr       (rd_addr),
    .win_idx    (win_idx)
  );

  DffPosRst #(.WIDTH(1)) u_mac_en  (.clk(clk), .rst(rst), .d(adv),          .q(mac_en));
  DffPosRst #(.WIDTH(1)) u_mac_clr (.clk(clk), .rst(rst), .d(adv && tap0),  .q(mac_clr));
  DffPosRst #(.WIDTH(1)) u_v1      (.clk(clk), .rst(rst), .d(adv && last_tap), .q(v1));
  DffPosRst #(.WIDTH(1)) u_valid   (.clk(clk), .rst(rst), .d(v1),           .q(out_valid));
  DffPosRst #(.WIDTH(1)) u_d1      (.clk(clk), .rst(rst), .d(adv && last_tap && last_window), .q(d1));
  DffPosRst #(.WIDTH(1)) u_done    (.clk(clk), .rst(rst), .d(d1),           .q(done));

  DffPosRst #(.WIDTH(ADDR_WIDTH)) u_a1 (
    .clk(clk), .rst(rst), .d((adv && last_tap) ? win_idx : a1), .q(a1)
  );
  DffPosRst #(.WIDTH(ADDR_WIDTH)) u_oaddr (
    .clk(clk), .rst(rst), .d(v1 ? a1 : out_addr), .q(out_addr)
  );

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: 4x4/K3 traces against a reference
// window walk, plus one full pass at default LeNet C1 geometry.
module tb_conv_window_sched;

  localparam int TW = 4;
  localparam int TK = 3;
  localparam int TO = 2;
  localparam int NT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_start, s_ready;
  logic       s_busy, s_done, s_rd_en, s_mac_clr, s_mac_en, s_ov;
  logic [9:0] s_rd_addr, s_oa;
  logic       b_start, b_ready;
  logic       b_busy, b_done, b_rd_en, b_mac_clr, b_mac_en, b_ov;
  logic [9:0] b_rd_addr, b_oa;

  int checks   = 0;
  int failures = 0;
  int pass_id  = 0;

  bit exp_rd   [NT];
  bit exp_en   [NT];
  bit exp_clr  [NT];
  bit exp_ov   [NT];
  bit exp_done [NT];
  bit exp_busy [NT];
  int exp_addr [NT];
  int exp_oa   [NT];

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(TW), .IMG_H(TW), .KSIZE(TK), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(s_start), .out_ready(s_ready),
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .mac_clr(s_mac_clr), .mac_en(s_mac_en), .out_valid(s_ov), .out_addr(s_oa)
  );

  conv_window_sched dut_big (
    .clk(clk), .rst(rst), .start(b_start), .out_ready(b_ready),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .mac_clr(b_mac_clr), .mac_en(b_mac_en), .out_valid(b_ov), .out_addr(b_oa)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference walk: window (r,c) tap (ky,kx) reads (r+ky)*TW + c+kx; bub idle
  // cycles precede window 2 with the address parked on its first tap.
  task automatic build_expected(input int bub);
    int cyc, w;
    for (int i = 0; i < NT; i++) begin
      exp_rd[i] = 0; exp_en[i] = 0; exp_clr[i] = 0; exp_ov[i] = 0;
      exp_done[i] = 0; exp_busy[i] = 0; exp_addr[i] = 0; exp_oa[i] = 0;
    end
    cyc = 1;
    w = 0;
    for (int r = 0; r < TO; r++) begin
      for (int c = 0; c < TO; c++) begin
        if (w == 2) begin
          for (int b = 0; b < bub; b++) begin
            exp_addr[cyc] = r * TW + c;
            cyc++;
          end
        end
        for (int ky = 0; ky < TK; ky++) begin
          for (int kx = 0; kx < TK; kx++) begin
            exp_rd[cyc]     = 1;
            exp_addr[cyc]   = (r + ky) * TW + c + kx;
            exp_en[cyc + 1] = 1;
            if (ky == 0 && kx == 0) exp_clr[cyc + 1] = 1;
            if (ky == TK - 1 && kx == TK - 1) begin
              exp_ov[cyc + 2] = 1;
              exp_oa[cyc + 2] = w;
            end
            cyc++;
          end
        end
        w++;
      end
    end
    exp_done[cyc + 1] = 1;
    for (int k = 1; k <= cyc + 1; k++) exp_busy[k] = 1;
  endtask

  // Called one cycle before the start edge; returns #1 after the edge ending cycle nc.
  task automatic run_pass(input int nc, input int bub, input int ra, input int rb, input int rst_at);
    int nreads, done_cyc;
    string p;
    pass_id++;
    nreads   = 0;
    done_cyc = 0;
    build_expected(bub);
    check($sformatf("p%0d_c0_busy", pass_id), s_busy, 0);
    check($sformatf("p%0d_c0_rd_en", pass_id), s_rd_en, 0);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 1; c <= nc; c++) begin
      s_ready = !(bub > 0 && c >= 19 && c < 19 + bub);
      s_start = (c == ra) || (c == rb);
      rst     = (c == rst_at);
      #1;
      p = $sformatf("p%0d_c%0d", pass_id, c);
      if (rst_at > 0 && c >= rst_at) begin
        check({p, "_rst_busy"},  s_busy, 0);
        check({p, "_rst_rd_en"}, s_rd_en, 0);
        check({p, "_rst_addr"},  s_rd_addr, 0);
        check({p, "_rst_en"},    s_mac_en, 0);
        check({p, "_rst_clr"},   s_mac_clr, 0);
        check({p, "_rst_ov"},    s_ov, 0);
        check({p, "_rst_oa"},    s_oa, 0);
        check({p, "_rst_done"},  s_done, 0);
      end else begin
        check({p, "_rd_en"},   s_rd_en, exp_rd[c]);
        check({p, "_rd_addr"}, s_rd_addr, exp_addr[c]);
        check({p, "_mac_en"},  s_mac_en, exp_en[c]);
        check({p, "_mac_clr"}, s_mac_clr, exp_clr[c]);
        check({p, "_ov"},      s_ov, exp_ov[c]);
        check({p, "_done"},    s_done, exp_done[c]);
        check({p, "_busy"},    s_busy, exp_busy[c]);
        if (exp_ov[c]) check({p, "_out_addr"}, s_oa, exp_oa[c]);
      end
      if (s_rd_en === 1'b1) nreads++;
      if (s_done === 1'b1) done_cyc = c;
      @(posedge clk); #1;
    end
    s_start = 1'b0;
    s_ready = 1'b1;
    rst     = 1'b0;
    if (rst_at == 0) begin
      check($sformatf("p%0d_n_reads", pass_id), nreads, 36);
      check($sformatf("p%0d_done_cycle", pass_id), done_cyc, 38 + bub);
    end
  endtask

  initial begin
    int nreads, last_addr, nov, last_oa, done_c, nclr;
    rst = 1'b1;
    s_start = 1'b0; s_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", s_busy, 0);
    check("reset_done", s_done, 0);
    check("reset_rd_en", s_rd_en, 0);
    check("reset_rd_addr", s_rd_addr, 0);
    check("reset_mac_clr", s_mac_clr, 0);
    check("reset_mac_en", s_mac_en, 0);
    check("reset_out_valid", s_ov, 0);
    check("reset_out_addr", s_oa, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_pass(38, 0, 0, 0, 0);   // plain pass, ends in cycle 38
    run_pass(45, 0, 0, 0, 0);   // start in cycle 39, back-to-back
    run_pass(45, 3, 0, 0, 0);   // 3-cycle bubble at window 2
    run_pass(45, 0, 5, 20, 0);  // start re-pulsed while busy
    run_pass(45, 0, 0, 0, 15);  // reset mid-pass
    run_pass(45, 0, 0, 0, 0);   // clean replay after reset

    nreads = 0; last_addr = -1; nov = 0; last_oa = -1; done_c = 0; nclr = 0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 1; c <= 14410; c++) begin
      if (b_rd_en === 1'b1) begin
        nreads++;
        last_addr = int'(b_rd_addr);
      end
      if (b_ov === 1'b1) begin
        nov++;
        last_oa = int'(b_oa);
      end
      if (b_mac_clr === 1'b1) nclr++;
      if (b_done === 1'b1) done_c = c;
      @(posedge clk); #1;
    end
    check("big_n_reads", nreads, 14400);
    check("big_last_rd_addr", last_addr, 783);
    check("big_n_out_valid", nov, 576);
    check("big_last_out_addr", last_oa, 575);
    check("big_done_cycle", done_c, 14402);
    check("big_n_mac_clr", nclr, 576);
    check("big_idle_after", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Scheduler for one convolution layer of the LeNet accelerator. It walks a KSIZE×KSIZE window over an IMG_W×IMG_H input feature map with stride 1, issuing one feature-map read per cycle. It also drives the clear/enable controls of the downstream MAC and tags each completed window with its output-map address. It sits between the layer-level sequencer (start/done) and the feature-map SRAM plus MAC datapath.

## Interface
- IMG_W, 28, input map width
- IMG_H, 28, input map height
- KSIZE, 5, kernel side; OW = IMG_W-KSIZE+1, OH = IMG_H-KSIZE+1
- ADDR_WIDTH, 10, read/output address width; must hold IMG_W*IMG_H-1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- out_ready  in  1  downstream can accept a new window; sampled only at tap 0
- busy  out  1  pass in progress
- done  out  1  single-cycle pulse, coincident with the final out_valid
- rd_en  out  1  feature-map read strobe
- rd_addr  out  ADDR_WIDTH  (row+ky)*IMG_W + (col+kx)
- mac_clr  out  1  first tap of a window reaches MAC (load, not accumulate)
- mac_en  out  1  tap data valid at MAC input
- out_valid  out  1  MAC result for a window is complete
- out_addr  out  ADDR_WIDTH  row*OW + col of the window flagged by out_valid

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start.
  - RUN→DRAIN after the read of the last tap of window (OH-1, OW-1).
  - DRAIN→IDLE after 2 cycles.
- Counters: kx (0..KSIZE-1) is innermost, then ky, col (0..OW-1), row (0..OH-1). All counters wrap to 0 on carry.
- Address generation uses a running window-base register plus a row-offset register. Both use additions of IMG_W or 1 only; no multiplier. out_addr uses a plain incrementing window counter.
- In RUN, each cycle issues one read (rd_en=1) and advances kx.
- Exception: at tap 0 of a window with out_ready=0, a bubble is inserted. rd_en=0 and counters hold until out_ready=1. out_ready is ignored at all other taps.
- Delay line, 2 stages: mac_en/mac_clr are rd_en/(tap==0) delayed 1 cycle, matching the 1-cycle SRAM latency. out_valid is last-tap delayed 2 cycles. out_addr is registered alongside out_valid.
- start while busy=1 is ignored.
- Reset mid-operation:
  - State returns to IDLE; counters and delay line clear.
  - No done and no out_valid is emitted for the aborted pass.
- Reset values: busy, done, rd_en, mac_clr, mac_en, out_valid = 0; rd_addr, out_addr = 0.

## Timing
- start accepted at edge E0. First rd_en is in the cycle after E0 (cycle 1), with rd_addr=0 and mac_clr=0. mac_clr and mac_en are high in cycle 2.
- No bubbles: rd_en is high in cycles 1..N, N = OW*OH*KSIZE². The final out_valid and done fall in cycle N+2.
- busy is high in cycles 1..N+2 and low in N+3. A start in cycle N+3 is accepted; there are no dead cycles.
- Each bubble adds exactly 1 cycle to all subsequent events.
- out_valid for window w is high exactly 2 cycles after that window's last read. Consecutive out_valid pulses are at least KSIZE² cycles apart.

## Structure
- Shared package lenet_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN);
  - the default layer constants (IMG_W/IMG_H/KSIZE for C1/C3);
  - a function computing OW/OH.
- Delay-line and output registers use the codebase's DffPosRst, consistent with the rst polarity.
- One sub-module is natural: conv_window_cnt. It holds the nested kx/ky/col/row counters with hold input, tap0/last_tap/last_window flags and address accumulators.

## Test plan
- IMG_W=IMG_H=4, KSIZE=3, out_ready=1, start pulse:
  - 36 reads; window 0 addresses 0,1,2,4,5,6,8,9,10; window 1 addresses 1,2,3,5,6,7,9,10,11.
  - out_addr 0,1,2,3; done in cycle 38; busy low in cycle 39.
- Same config, out_ready=0 for 3 cycles at window 2 tap 0:
  - rd_en low exactly 3 cycles, address held at 4; done in cycle 41.
- Same config, start re-pulsed in cycles 5 and 20: ignored; the trace is identical to test 1.
- Same config, rst asserted in cycle 15:
  - All outputs 0 immediately; no out_valid or done afterwards.
  - A new start then replays the test 1 trace exactly.
- Back-to-back: start in cycle 39 after a pass → first rd_en in cycle 40 with rd_addr=0.
- Default parameters:
  - 14400 reads; last rd_addr 783; 576 out_valid pulses; last out_addr 575.
  - done in cycle 14402; mac_clr count = 576.
